// File: rtl/softstart_pkg.sv
// Shared types and default constants for the soft-start sequencer.
// SOFTSTART_SEQ_RAMPDOWN_EN adds the RAMPDN state to the state enum.
package softstart_pkg;

  localparam int CODE_W_DEF     = 8;
  localparam int DIV_W_DEF      = 10;
  localparam int PRECHG_CYC_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRECHG = 3'd1,
    S_RAMP   = 3'd2,
    S_DONE   = 3'd3,
`ifdef SOFTSTART_SEQ_RAMPDOWN_EN
    S_RAMPDN = 3'd5,
`endif
    S_FAULT  = 3'd4
  } ss_state_t;

  // States that report ss_busy.
  function automatic logic is_busy(ss_state_t s);
    logic b;
    b = (s == S_PRECHG) || (s == S_RAMP);
`ifdef SOFTSTART_SEQ_RAMPDOWN_EN
    if (s == S_RAMPDN) b = 1'b1;
`endif
    return b;
  endfunction

endpackage

// File: rtl/softstart_presc.sv
// Ramp step prescaler: counts 0..i_div while i_run, pulses o_tc on the
// terminal count. Ports: clk, rst, i_clr, i_run, i_div, o_tc.
module softstart_presc
  import softstart_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tc
);

  logic [DIV_W-1:0] r_cnt;

  // >= keeps the count bounded if i_div shrinks mid-count.
  assign o_tc = i_run && (r_cnt >= i_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || !i_run || o_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/softstart_seq.sv
// Soft-start sequencer: IDLE -> PRECHG -> RAMP -> DONE, with FAULT latch.
// Ports: clk, rst, en, fault, target, step_div -> ss_code, drv_en,
// ss_busy, ss_done, fault_latched. SOFTSTART_SEQ_RAMPDOWN_EN: ramp down.
module softstart_seq
  import softstart_pkg::*;
#(
  parameter int CODE_W     = CODE_W_DEF,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int PRECHG_CYC = PRECHG_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fault,
  input  logic [CODE_W-1:0] target,
  input  logic [DIV_W-1:0]  step_div,
  output logic [CODE_W-1:0] ss_code,
  output logic              drv_en,
  output logic              ss_busy,
  output logic              ss_done,
  output logic              fault_latched
);

  localparam int PC_W =
    (PRECHG_CYC > 1) ? $clog2(PRECHG_CYC) : 1;
  localparam logic [PC_W-1:0] PC_LAST =
    PC_W'(PRECHG_CYC - 1);
  localparam logic [CODE_W-1:0] C_ONE = CODE_W'(1);

`ifdef SOFTSTART_SEQ_RAMPDOWN_EN
  localparam ss_state_t S_OFF = S_RAMPDN;
`else
  localparam ss_state_t S_OFF = S_IDLE;
`endif

  ss_state_t         r_state;
  ss_state_t         w_nxt;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] w_code_nxt;
  logic [CODE_W-1:0] r_tq;
  logic [CODE_W-1:0] w_tq_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_nxt;
  logic              r_drv;
  logic              r_busy;
  logic              r_done;
  logic              r_flt;
  logic              w_drv_nxt;
  logic              w_run;
  logic              w_clr;
  logic              w_tc;

  always_comb begin
    w_run = (r_state == S_RAMP);
`ifdef SOFTSTART_SEQ_RAMPDOWN_EN
    if (r_state == S_RAMPDN) w_run = 1'b1;
`endif
  end

  // Any state change restarts the step timing.
  assign w_clr = (w_nxt != r_state);

  softstart_presc #(
    .DIV_W (DIV_W)
  ) u_presc (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_run (w_run),
    .i_div (step_div),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_nxt      = r_state;
    w_code_nxt = r_code;
    w_tq_nxt   = r_tq;
    w_pc_nxt   = r_pc;
    if (fault) begin
      w_nxt = S_FAULT;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (en) begin
            w_nxt    = S_PRECHG;
            w_tq_nxt = target;
          end
        end
        S_PRECHG: begin
          if (!en) begin
            w_nxt = S_OFF;
          end else if (r_pc == PC_LAST) begin
            w_nxt = S_RAMP;
          end else begin
            w_pc_nxt = r_pc + PC_W'(1);
          end
        end
        S_RAMP: begin
          if (!en) begin
            w_nxt = S_OFF;
          end else if (r_code == r_tq) begin
            w_nxt = S_DONE;
          end else if (w_tc) begin
            // r_code < r_tq here, so +1 cannot wrap.
            w_code_nxt = r_code + C_ONE;
            if (w_code_nxt == r_tq) w_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (!en) w_nxt = S_OFF;
        end
`ifdef SOFTSTART_SEQ_RAMPDOWN_EN
        S_RAMPDN: begin
          if (en) begin
            w_nxt = S_RAMP;
          end else if (r_code == '0) begin
            w_nxt = S_IDLE;
          end else if (w_tc) begin
            w_code_nxt = r_code - C_ONE;
            if (w_code_nxt == '0) w_nxt = S_IDLE;
          end
        end
`endif
        S_FAULT: begin
          if (!en) w_nxt = S_IDLE;
        end
        default: begin
          w_nxt = S_IDLE;
        end
      endcase
    end
    if (w_nxt == S_IDLE || w_nxt == S_FAULT) begin
      w_code_nxt = '0;
    end
    if (w_nxt != S_PRECHG) begin
      w_pc_nxt = '0;
    end
  end

  always_comb begin
    w_drv_nxt = (w_nxt == S_RAMP) || (w_nxt == S_DONE);
`ifdef SOFTSTART_SEQ_RAMPDOWN_EN
    // Driver stays on while the reference is still above zero.
    if (w_nxt == S_RAMPDN && w_code_nxt != '0) w_drv_nxt = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_tq    <= '0;
      r_pc    <= '0;
      r_drv   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_flt   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_code  <= w_code_nxt;
      r_tq    <= w_tq_nxt;
      r_pc    <= w_pc_nxt;
      r_drv   <= w_drv_nxt;
      r_busy  <= is_busy(w_nxt);
      r_done  <= (w_nxt == S_DONE);
      r_flt   <= (w_nxt == S_FAULT);
    end
  end

  assign ss_code       = r_code;
  assign drv_en        = r_drv;
  assign ss_busy       = r_busy;
  assign ss_done       = r_done;
  assign fault_latched = r_flt;

endmodule
